// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter
// Owns the shared 7800 system bus. It hands the bus to the CPU, to MARIA
// display-list DMA, or to the RAM-clear engine, and drives CPU RDY so that
// DMA only takes the bus on a CPU read cycle.
//
// Ports
//   clk_sys, reset       system clock, async active-high reset
//   pclk1                one-clk_sys pulse per CPU cycle
//   loading              ROM load in progress; forces RAM clear
//   cpu_addr/rwn/dout    CPU bus request
//   dma_req, dma_addr    MARIA bus request (level) and address
//   bus_addr/rwn/wdata   arbitrated bus (combinational from state)
//   ram_clr_we           RAM clear write strobe
//   cpu_rdy              CPU RDY, 0 = stall
//   dma_grant            MARIA owns the bus
//   clear_done           full clear pass done since loading rose
//   halt_err             sticky, a grant was forced by the halt timeout
//   dma_cycles           pclk1 pulses in current/last DMA tenure
//
// state      | meaning
// -----------+---------------------------------------------------------
// CPU        | CPU owns the bus, RDY high
// HALT_WAIT  | RDY low, waiting for a CPU read cycle before granting DMA
// DMA        | MARIA owns the bus
// RELEASE    | one-CPU-cycle turnaround back to the CPU, RDY still low
// CLEAR      | RAM clear engine writes zeros to every location

module sys_bus_arbiter #(
    parameter int CLEAR_AW     = 11,
    parameter int HALT_TIMEOUT = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        pclk1,
    input  logic        loading,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rwn,
    input  logic [7:0]  cpu_dout,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    output logic [15:0] bus_addr,
    output logic        bus_rwn,
    output logic [7:0]  bus_wdata,
    output logic        ram_clr_we,
    output logic        cpu_rdy,
    output logic        dma_grant,
    output logic        clear_done,
    output logic        halt_err,
    output logic [15:0] dma_cycles
);

    localparam int TW = $clog2(HALT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_CPU,
        ST_HALT_WAIT,
        ST_DMA,
        ST_RELEASE,
        ST_CLEAR
    } state_t;

    state_t              state, state_nxt;
    logic [CLEAR_AW-1:0] clr_cnt, clr_cnt_nxt;
    logic [TW-1:0]       tmo_cnt, tmo_cnt_nxt;
    logic                halt_err_nxt;
    logic                clear_done_nxt;
    logic [15:0]         dma_cycles_nxt;
    logic                loading_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_CPU;
            clr_cnt    <= '0;
            tmo_cnt    <= '0;
            cpu_rdy    <= 1'b1;
            dma_grant  <= 1'b0;
            ram_clr_we <= 1'b0;
            clear_done <= 1'b0;
            halt_err   <= 1'b0;
            dma_cycles <= '0;
            loading_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            cpu_rdy    <= (state_nxt == ST_CPU);
            dma_grant  <= (state_nxt == ST_DMA);
            ram_clr_we <= (state_nxt == ST_CLEAR);
            clear_done <= clear_done_nxt;
            halt_err   <= halt_err_nxt;
            dma_cycles <= dma_cycles_nxt;
            loading_q  <= loading;
        end
    end

    always_comb begin
        state_nxt      = state;
        clr_cnt_nxt    = clr_cnt;
        tmo_cnt_nxt    = tmo_cnt;
        halt_err_nxt   = halt_err;
        clear_done_nxt = clear_done;
        dma_cycles_nxt = dma_cycles;

        // Counts every pclk1 spent owning the bus, including the one on
        // which the tenure ends.
        if (state == ST_DMA && pclk1 && dma_cycles != 16'hFFFF)
            dma_cycles_nxt = dma_cycles + 16'd1;

        if (loading && !loading_q)
            clear_done_nxt = 1'b0;

        if (loading) begin
            // Loading aborts whatever is in flight, DMA included.
            state_nxt = ST_CLEAR;
            if (state == ST_CLEAR) begin
                clr_cnt_nxt = clr_cnt + CLEAR_AW'(1);
                if (&clr_cnt)
                    clear_done_nxt = 1'b1;
            end
        end else begin
            case (state)
                ST_CPU: begin
                    if (dma_req) begin
                        state_nxt   = ST_HALT_WAIT;
                        tmo_cnt_nxt = '0;
                    end
                end
                ST_HALT_WAIT: begin
                    // A grant on this pulse wins over dma_req dropping; the
                    // tenure then ends through RELEASE.
                    if (pclk1 && cpu_rwn) begin
                        state_nxt      = ST_DMA;
                        dma_cycles_nxt = '0;
                    end else if (pclk1 && tmo_cnt == TW'(HALT_TIMEOUT - 1)) begin
                        state_nxt      = ST_DMA;
                        dma_cycles_nxt = '0;
                        halt_err_nxt   = 1'b1;
                    end else begin
                        if (pclk1)
                            tmo_cnt_nxt = tmo_cnt + TW'(1);
                        if (!dma_req)
                            state_nxt = ST_CPU;
                    end
                end
                ST_DMA: begin
                    if (!dma_req)
                        state_nxt = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (pclk1)
                        state_nxt = ST_CPU;
                end
                ST_CLEAR: begin
                    state_nxt   = ST_CPU;
                    clr_cnt_nxt = '0;
                end
                default: state_nxt = ST_CPU;
            endcase
        end
    end

    // HALT_WAIT and RELEASE keep the CPU on the bus: a 6502 finishes its
    // pending writes even with RDY low.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_rwn   = cpu_rwn;
        bus_wdata = cpu_dout;
        case (state)
            ST_DMA: begin
                bus_addr = dma_addr;
                bus_rwn  = 1'b1;
            end
            ST_CLEAR: begin
                bus_addr  = 16'(clr_cnt);
                bus_rwn   = 1'b0;
                bus_wdata = 8'h00;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
module tb_sys_bus_arbiter;

    localparam int CLEAR_AW     = 11;
    localparam int HALT_TIMEOUT = 8;
    localparam int NCLR         = 1 << CLEAR_AW;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        pclk1   = 1'b0;
    logic        loading = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rwn  = 1'b1;
    logic [7:0]  cpu_dout = 8'h00;
    logic        dma_req  = 1'b0;
    logic [15:0] dma_addr = 16'h0000;
    logic [15:0] bus_addr;
    logic        bus_rwn;
    logic [7:0]  bus_wdata;
    logic        ram_clr_we;
    logic        cpu_rdy;
    logic        dma_grant;
    logic        clear_done;
    logic        halt_err;
    logic [15:0] dma_cycles;

    sys_bus_arbiter #(.CLEAR_AW(CLEAR_AW), .HALT_TIMEOUT(HALT_TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset), .pclk1(pclk1), .loading(loading),
        .cpu_addr(cpu_addr), .cpu_rwn(cpu_rwn), .cpu_dout(cpu_dout),
        .dma_req(dma_req), .dma_addr(dma_addr),
        .bus_addr(bus_addr), .bus_rwn(bus_rwn), .bus_wdata(bus_wdata),
        .ram_clr_we(ram_clr_we), .cpu_rdy(cpu_rdy), .dma_grant(dma_grant),
        .clear_done(clear_done), .halt_err(halt_err), .dma_cycles(dma_cycles)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, plus two flags for the RDY-low
    // phases around a DMA tenure.
    int m_owner;          // 0 cpu, 1 maria, 2 clear engine
    bit m_wait;           // cpu stalled, waiting for a read cycle
    bit m_turn;           // cpu stalled, turnaround after dma
    int m_wr_pulses;
    int m_clr_addr;
    int m_dcyc;
    bit m_done, m_err, m_load_prev;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_owner = 0; m_wait = 0; m_turn = 0; m_wr_pulses = 0;
            m_clr_addr = 0; m_dcyc = 0; m_done = 0; m_err = 0; m_load_prev = 0;
        end else begin
            if (m_owner == 1 && pclk1 && m_dcyc < 65535) m_dcyc++;
            if (loading) begin
                if (!m_load_prev) m_done = 0;
                if (m_owner == 2) begin
                    m_clr_addr = (m_clr_addr + 1) % NCLR;
                    if (m_clr_addr == 0) m_done = 1;
                end
                m_owner = 2; m_wait = 0; m_turn = 0;
            end else if (m_owner == 2) begin
                m_owner = 0; m_clr_addr = 0;
            end else if (m_owner == 1) begin
                if (!dma_req) begin m_owner = 0; m_turn = 1; end
            end else if (m_turn) begin
                if (pclk1) m_turn = 0;
            end else if (m_wait) begin
                if (pclk1 && cpu_rwn) begin
                    m_owner = 1; m_wait = 0; m_dcyc = 0;
                end else begin
                    if (pclk1) m_wr_pulses++;
                    if (m_wr_pulses >= HALT_TIMEOUT) begin
                        m_owner = 1; m_wait = 0; m_dcyc = 0; m_err = 1;
                    end else if (!dma_req) begin
                        m_wait = 0;
                    end
                end
            end else if (dma_req) begin
                m_wait = 1; m_wr_pulses = 0;
            end
            m_load_prev = loading;
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk_sys) begin
        if (chk_en) begin
            logic [15:0] e_addr;
            logic        e_rwn;
            logic [7:0]  e_wd;
            e_addr = cpu_addr; e_rwn = cpu_rwn; e_wd = cpu_dout;
            if (m_owner == 1) begin e_addr = dma_addr; e_rwn = 1'b1; end
            if (m_owner == 2) begin e_addr = 16'(m_clr_addr); e_rwn = 1'b0; e_wd = 8'h00; end
            chk("bus_addr",   bus_addr,          e_addr);
            chk("bus_rwn",    16'(bus_rwn),      16'(e_rwn));
            chk("bus_wdata",  16'(bus_wdata),    16'(e_wd));
            chk("cpu_rdy",    16'(cpu_rdy),      16'(m_owner == 0 && !m_wait && !m_turn));
            chk("dma_grant",  16'(dma_grant),    16'(m_owner == 1));
            chk("ram_clr_we", 16'(ram_clr_we),   16'(m_owner == 2));
            chk("clear_done", 16'(clear_done),   16'(m_done));
            chk("halt_err",   16'(halt_err),     16'(m_err));
            chk("dma_cycles", dma_cycles,        16'(m_dcyc));
        end
    end

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse();
        pclk1 = 1'b1;
        cyc();
        pclk1 = 1'b0;
    endtask

    task automatic at_neg();
        @(negedge clk_sys);
        #1;
    endtask

    bit written [NCLR];
    int missing;

    initial begin
        repeat (3) cyc();
        cpu_addr = 16'h0ABC;
        reset = 1'b0;
        chk_en = 1'b1;
        at_neg();
        chk("rst_cpu_rdy", 16'(cpu_rdy), 16'd1);
        chk("rst_grant", 16'(dma_grant), 16'd0);
        chk("rst_clr_we", 16'(ram_clr_we), 16'd0);
        chk("rst_bus_addr", bus_addr, 16'h0ABC);

        // basic DMA
        cpu_rwn = 1'b1; dma_addr = 16'h1F00; dma_req = 1'b1;
        cyc();
        pulse();
        at_neg();
        chk("basic_grant", 16'(dma_grant), 16'd1);
        chk("basic_addr", bus_addr, 16'h1F00);
        repeat (5) begin pulse(); cyc(); end
        at_neg();
        chk("basic_dcyc", dma_cycles, 16'd5);
        chk("model_dcyc", 16'(m_dcyc), 16'd5);
        dma_req = 1'b0;
        cyc();
        at_neg();
        chk("release_rdy", 16'(cpu_rdy), 16'd0);
        pulse();
        at_neg();
        chk("back_rdy", 16'(cpu_rdy), 16'd1);

        // write-pending halt
        cpu_rwn = 1'b0; dma_req = 1'b1;
        cyc();
        repeat (3) begin pulse(); cyc(); end
        at_neg();
        chk("wp_no_grant", 16'(dma_grant), 16'd0);
        cpu_rwn = 1'b1;
        pulse();
        at_neg();
        chk("wp_grant", 16'(dma_grant), 16'd1);
        chk("wp_halt_err", 16'(halt_err), 16'd0);
        dma_req = 1'b0;
        cyc(); pulse();

        // timeout
        cpu_rwn = 1'b0; dma_req = 1'b1;
        cyc();
        repeat (7) begin pulse(); cyc(); end
        at_neg();
        chk("to_no_grant", 16'(dma_grant), 16'd0);
        pulse();
        at_neg();
        chk("to_grant", 16'(dma_grant), 16'd1);
        chk("to_halt_err", 16'(halt_err), 16'd1);
        chk("model_err", 16'(m_err), 16'd1);
        dma_req = 1'b0;
        cyc(); pulse();
        cpu_rwn = 1'b1; dma_req = 1'b1;
        cyc(); pulse();
        at_neg();
        chk("to_sticky", 16'(halt_err), 16'd1);

        // reset mid-DMA
        pulse(); pulse();
        cpu_addr = 16'h1234; dma_req = 1'b0; reset = 1'b1;
        at_neg();
        chk("rmd_rdy", 16'(cpu_rdy), 16'd1);
        chk("rmd_grant", 16'(dma_grant), 16'd0);
        chk("rmd_dcyc", dma_cycles, 16'd0);
        chk("rmd_addr", bus_addr, 16'h1234);
        cyc();
        reset = 1'b0;
        cyc();

        // RAM clear
        loading = 1'b1;
        for (int i = 1; i <= 2100; i++) begin
            cyc();
            at_neg();
            if (ram_clr_we && !bus_rwn && bus_wdata == 8'h00 && bus_addr < 16'(NCLR))
                written[bus_addr] = 1'b1;
            if (i == 1)    chk("clr_first_addr", bus_addr, 16'h0000);
            if (i == 2048) chk("clr_done_2048", 16'(clear_done), 16'd0);
            if (i == 2049) chk("clr_done_2049", 16'(clear_done), 16'd1);
        end
        missing = 0;
        for (int a = 0; a < NCLR; a++) if (!written[a]) missing++;
        chk("clr_missing", 16'(missing), 16'd0);
        loading = 1'b0;
        cyc();
        at_neg();
        chk("clr_exit_rdy", 16'(cpu_rdy), 16'd1);
        chk("clr_exit_we", 16'(ram_clr_we), 16'd0);

        // abort DMA with loading
        cpu_rwn = 1'b1; dma_req = 1'b1;
        cyc(); pulse();
        loading = 1'b1;
        cyc();
        at_neg();
        chk("abort_grant", 16'(dma_grant), 16'd0);
        chk("abort_we", 16'(ram_clr_we), 16'd1);
        chk("abort_addr", bus_addr, 16'h0000);
        loading = 1'b0; dma_req = 1'b0;
        cyc();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit wr_bias;
            wr_bias = ((i / 400) % 2) == 1;
            pclk1    = ($urandom_range(2) == 0);
            cpu_rwn  = wr_bias ? ($urandom_range(9) == 0) : 1'($urandom_range(1));
            cpu_addr = 16'($urandom);
            cpu_dout = 8'($urandom);
            dma_addr = 16'($urandom);
            if ($urandom_range(11) == 0) dma_req = ~dma_req;
            if (loading) begin
                if ($urandom_range(7) == 0) loading = 1'b0;
            end else if ($urandom_range(199) == 0) begin
                loading = 1'b1;
            end
            cyc();
        end
        pclk1 = 1'b0; loading = 1'b0; dma_req = 1'b0;
        cyc();
        at_neg();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_bus_arbiter.md
# sys_bus_arbiter

Owns the shared system address/data bus in the 7800 core. It sequences ownership between the CPU (T65), MARIA display-list DMA, and a power-on/load RAM-clear engine. It drives the CPU RDY stall handshake so that DMA only takes the bus on a CPU read cycle, and produces the final bus address/RW/write data feeding RAM0/RAM1, the chip-select decoder, TIA, RIOT and the cartridge.

## Interface
Parameters:
- CLEAR_AW, 11, RAM-clear address width (clears 2^CLEAR_AW locations)
- HALT_TIMEOUT, 8, max pclk1 pulses spent in HALT_WAIT before a forced grant

Ports:
- clk_sys  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- pclk1  in  1  CPU cycle enable, one clk_sys-wide pulse per CPU cycle
- loading  in  1  ROM load in progress; requests RAM clear
- cpu_addr  in  16  CPU address
- cpu_rwn  in  1  CPU read(1)/write(0)
- cpu_dout  in  8  CPU write data
- dma_req  in  1  MARIA bus request, level, held until DMA finished
- dma_addr  in  16  MARIA DMA address
- bus_addr  out  16  arbitrated address
- bus_rwn  out  1  arbitrated read/write
- bus_wdata  out  8  arbitrated write data
- ram_clr_we  out  1  write strobe for RAM clear
- cpu_rdy  out  1  CPU RDY (0 = stall)
- dma_grant  out  1  MARIA owns bus
- clear_done  out  1  full clear pass completed since loading rose
- halt_err  out  1  sticky: forced grant after timeout
- dma_cycles  out  16  pclk1 pulses in the current/last DMA tenure

## Operation
- States: CPU, HALT_WAIT, DMA, RELEASE, CLEAR. Reset state CPU.
- Reset values: cpu_rdy=1, dma_grant=0, ram_clr_we=0, clear_done=0, halt_err=0, dma_cycles=0, clear counter=0, timeout counter=0.
- loading=1 overrides all: from any state, next state is CLEAR; dma_grant and cpu_rdy drop to 0 the same edge. A DMA in progress is aborted.
- CLEAR: counter increments every clk_sys; ram_clr_we=1; bus_addr={zeros, counter}, bus_rwn=0, bus_wdata=0. When counter wraps from all-ones to 0, clear_done sets, and it stays set until loading next rises. Clearing continues (rewriting zeros) while loading stays high. When loading=0, go to CPU, counter:=0, cpu_rdy:=1.
- CPU: bus follows cpu_*. dma_req=1 → HALT_WAIT with cpu_rdy:=0, timeout counter:=0.
- HALT_WAIT: bus still follows CPU, because a 6502 completes pending writes despite RDY. On a pclk1 pulse with cpu_rwn=1 → DMA. On a pclk1 pulse with cpu_rwn=0, increment the timeout. If the timeout reaches HALT_TIMEOUT → DMA and set halt_err. If dma_req drops before the grant → CPU with cpu_rdy:=1.
- DMA: dma_grant=1, bus_addr=dma_addr, bus_rwn=1, bus_wdata=cpu_dout. dma_cycles is cleared on entry and increments per pclk1, saturating at 0xFFFF. dma_req=0 → RELEASE with dma_grant:=0.
- RELEASE: bus follows the CPU with cpu_rdy still 0. On the next pclk1 pulse → CPU with cpu_rdy:=1 (one turnaround cycle). dma_req=1 seen in RELEASE is held off until CPU, then re-arbitrated normally.
- Simultaneous events: loading beats everything. In HALT_WAIT, a read-cycle pclk1 coinciding with timeout expiry takes the read path, and halt_err stays clear. dma_req falling on the same edge as a grant still enters DMA, then leaves via RELEASE.

## Timing
- State, cpu_rdy, dma_grant, ram_clr_we, clear_done, halt_err and dma_cycles are registered and update on the clk_sys edge where their condition is sampled.
- bus_addr, bus_rwn and bus_wdata are combinational muxes from the registered state. There is no extra latency beyond the state register.
- Grant latency: 1 clk_sys after the first read-cycle pclk1 following dma_req. Worst case is HALT_TIMEOUT pclk1 pulses.
- Release latency: the first pclk1 after dma_req falls, plus 1 clk_sys.
- A full clear takes 2^CLEAR_AW clk_sys cycles. clear_done asserts on the edge after address all-ones is written.

## Test plan
- Reset mid-DMA: assert reset while in DMA → next sample shows cpu_rdy=1, dma_grant=0, dma_cycles=0, with the bus following cpu_addr.
- Basic DMA: cpu_rwn=1, raise dma_req, pulse pclk1 → dma_grant=1 and bus_addr=dma_addr=0x1F00. Give 5 pclk1 → dma_cycles=5. Drop dma_req, pulse pclk1 → cpu_rdy=1 after one turnaround.
- Write-pending halt: dma_req with cpu_rwn=0 for 3 pclk1, then 1 → grant occurs on the 4th pulse, halt_err=0.
- Timeout: hold cpu_rwn=0 for 8 pclk1 after dma_req → dma_grant=1, halt_err=1 (sticky through the next DMA).
- Clear: loading=1 for 2100 clk_sys → every address 0x000–0x7FF is written with 0 and ram_clr_we=1. clear_done=1 at cycle 2049. Drop loading → state CPU, cpu_rdy=1.
- Abort: raise loading during DMA → dma_grant=0 next edge and ram_clr_we=1 with bus_addr=0x0000.
